dual_port_ram_pipelined: RTL and testbench

Parametrised single-clock simple dual-port RAM: one write port, one read port, per-byte write enables, selectable read latency, defined read-during-write behaviour, and an optional power-up initialisation sweep. It is the general-purpose storage primitive for feature-map, weight and partial-sum buffers in the accelerator datapath. It replaces ad-hoc single-latency RAMs wherever consumers need a valid strobe, byte masking or guaranteed-clean contents after reset.

---
 rtl/dual_port_ram_pipelined_pkg.sv | 24 ++
 rtl/dual_port_ram_pipelined_ram_init_seq.sv | 48 ++++
 rtl/dual_port_ram_pipelined.sv | 145 ++++++++++++++
 tb/tb_dual_port_ram_pipelined.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_port_ram_pipelined_pkg.sv
// Shared constants and helpers for the pipelined simple dual-port RAM.
package dual_port_ram_pipelined_pkg;

    // Read-during-write behaviour on a same-address collision
    localparam int RDW_OLD = 0;   // read returns the word as it was before the write
    localparam int RDW_NEW = 1;   // read returns the byte-merged word being written

    // Initialisation sequencer state encodings
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Address width for a given depth; at least one bit so ports never collapse.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dual_port_ram_pipelined_ram_init_seq.sv
// Power-up initialisation sequencer: sweeps every word once after reset,
// then hands the write port over to the user.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | writing the init word to address count, one word per cycle
// ST_RUN  | sweep done (or disabled); user ports own the array
module ram_init_seq
    import dual_port_ram_pipelined_pkg::*;
#(
    parameter int C_RAM_DEPTH = 512,
    parameter int C_INIT_EN   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          init_busy,
    output logic                          init_wr,
    output logic [clog2(C_RAM_DEPTH)-1:0] init_addr
);

    localparam int              AW        = clog2(C_RAM_DEPTH);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(C_RAM_DEPTH - 1);
    localparam logic [0:0]      ST_RESET  = (C_INIT_EN != 0) ? ST_INIT : ST_RUN;

    logic [0:0]    state;
    logic [AW-1:0] count;

    // Walk the address counter through the whole array, leave INIT on the last word.
    // A reset at any point restarts the sweep from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RESET;
            count <= '0;
        end else if (state == ST_INIT) begin
            if (count == LAST_ADDR) begin
                state <= ST_RUN;
                count <= '0;
            end else begin
                count <= count + AW'(1);
            end
        end
    end

    assign init_busy = (state == ST_INIT);
    assign init_wr   = init_busy;
    assign init_addr = count;

endmodule

// File: rtl/dual_port_ram_pipelined.sv
// Single-clock simple dual-port RAM with byte enables, a configurable read
// pipeline with valid strobe, defined read-during-write behaviour, an
// optional init sweep and a sticky out-of-range address flag.
module dual_port_ram_pipelined
    import dual_port_ram_pipelined_pkg::*;
#(
    parameter int                     C_RAM_WIDTH  = 64,
    parameter int                     C_RAM_DEPTH  = 512,
    parameter int                     C_RD_LATENCY = 1,
    parameter int                     C_RDW_MODE   = RDW_OLD,
    parameter int                     C_INIT_EN    = 1,
    parameter logic [C_RAM_WIDTH-1:0] C_INIT_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [clog2(C_RAM_DEPTH)-1:0] wrAddr,
    input  logic [C_RAM_WIDTH-1:0]        datain,
    input  logic                          wren,
    input  logic [C_RAM_WIDTH/8-1:0]      byteen,
    input  logic [clog2(C_RAM_DEPTH)-1:0] rdAddr,
    input  logic                          rden,
    output logic [C_RAM_WIDTH-1:0]        dataout,
    output logic                          dataout_valid,
    output logic                          init_busy,
    output logic                          addr_err
);

    localparam int            AW        = clog2(C_RAM_DEPTH);
    localparam int            NB        = C_RAM_WIDTH / 8;
    localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(C_RAM_DEPTH);

    logic [C_RAM_WIDTH-1:0] mem [C_RAM_DEPTH];

    logic                   init_wr;
    logic [AW-1:0]          init_addr;
    logic                   run;
    logic                   wr_in_range;
    logic                   rd_in_range;
    logic                   user_wr;
    logic                   rd_accept;
    logic                   collide;

    logic                   mem_we;
    logic [AW-1:0]          mem_waddr;
    logic [C_RAM_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]          mem_be;
    logic [C_RAM_WIDTH-1:0] rd_word;

    logic [C_RAM_WIDTH-1:0] pipe_data [C_RD_LATENCY];
    logic [C_RD_LATENCY-1:0] pipe_valid;

    ram_init_seq #(
        .C_RAM_DEPTH (C_RAM_DEPTH),
        .C_INIT_EN   (C_INIT_EN)
    ) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_busy (init_busy),
        .init_wr   (init_wr),
        .init_addr (init_addr)
    );

    // Depth need not be a power of two, so addresses are range-checked explicitly.
    assign run         = ~init_busy;
    assign wr_in_range = ({1'b0, wrAddr} < DEPTH_LIM);
    assign rd_in_range = ({1'b0, rdAddr} < DEPTH_LIM);
    assign user_wr     = run & wren & wr_in_range & (|byteen);
    assign rd_accept   = run & rden;
    assign collide     = user_wr & rd_accept & rd_in_range & (wrAddr == rdAddr);

    // Init sweep owns the write port while busy; it always writes whole words.
    always_comb begin
        mem_we    = init_wr | user_wr;
        mem_waddr = wrAddr;
        mem_wdata = datain;
        mem_be    = byteen;
        if (init_wr) begin
            mem_waddr = init_addr;
            mem_wdata = C_INIT_VALUE;
            mem_be    = '1;
        end
    end

    // Byte-masked array write; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read word seen by the first pipeline stage: zero when out of range,
    // byte-merged with the incoming write on a collision in new-data mode.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rdAddr];
            if (C_RDW_MODE == RDW_NEW && collide) begin
                for (int b = 0; b < NB; b++) begin
                    if (byteen[b]) begin
                        rd_word[8*b +: 8] = datain[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read pipeline: valid tokens always advance; data registers only load
    // behind a valid token so the output holds its last result between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            for (int k = 0; k < C_RD_LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_accept;
            if (rd_accept) begin
                pipe_data[0] <= rd_word;
            end
            for (int k = 1; k < C_RD_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                if (pipe_valid[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    assign dataout       = pipe_data[C_RD_LATENCY-1];
    assign dataout_valid = pipe_valid[C_RD_LATENCY-1];

    // Sticky flag for any out-of-range address presented with a request in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (run && ((wren && !wr_in_range) || (rden && !rd_in_range))) begin
            addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dual_port_ram_pipelined.sv
// Bench for dual_port_ram_pipelined: two instances share one stimulus stream.
// A: depth 512, latency 3, old-data collisions, init to zero.
// B: depth 500, latency 1, new-data collisions, init to a non-zero pattern.
module tb_dual_port_ram_pipelined;

    localparam logic [63:0] IVAL_B = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [8:0]  wr_addr = '0;
    logic [63:0] datain = '0;
    logic        wren = 1'b0;
    logic [7:0]  byteen = '0;
    logic [8:0]  rd_addr = '0;
    logic        rden = 1'b0;

    logic [63:0] dout_a, dout_b;
    logic        dv_a, dv_b, busy_a, busy_b, err_a, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dual_port_ram_pipelined #(
        .C_RAM_WIDTH(64), .C_RAM_DEPTH(512), .C_RD_LATENCY(3),
        .C_RDW_MODE(0), .C_INIT_EN(1), .C_INIT_VALUE(64'h0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .wrAddr(wr_addr), .datain(datain), .wren(wren),
        .byteen(byteen), .rdAddr(rd_addr), .rden(rden), .dataout(dout_a),
        .dataout_valid(dv_a), .init_busy(busy_a), .addr_err(err_a)
    );

    dual_port_ram_pipelined #(
        .C_RAM_WIDTH(64), .C_RAM_DEPTH(500), .C_RD_LATENCY(1),
        .C_RDW_MODE(1), .C_INIT_EN(1), .C_INIT_VALUE(IVAL_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .wrAddr(wr_addr), .datain(datain), .wren(wren),
        .byteen(byteen), .rdAddr(rd_addr), .rden(rden), .dataout(dout_b),
        .dataout_valid(dv_b), .init_busy(busy_b), .addr_err(err_b)
    );

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic        v;
        logic [63:0] d;
    } tok_t;

    int          depth_m [2] = '{512, 500};
    int          lat_m   [2] = '{3, 1};
    int          mode_m  [2] = '{0, 1};
    logic [63:0] ival_m  [2] = '{64'h0, IVAL_B};
    logic [63:0] mem_m   [2][512];
    tok_t        q_m     [2][$];
    int          busy_m  [2];
    logic        ev_m    [2];
    logic [63:0] ed_m    [2];
    logic        err_m   [2];

    function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // After reset every word will hold the init value before any user access can occur.
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 512; a++) mem_m[i][a] = ival_m[i];
            q_m[i].delete();
            busy_m[i] = depth_m[i];
            ev_m[i]   = 1'b0;
            ed_m[i]   = '0;
            err_m[i]  = 1'b0;
        end
    endtask

    // One clock edge of the reference: reads are delayed by lat_m cycles.
    task automatic model_edge();
        tok_t        t;
        logic [63:0] d;
        logic        ra_ok, wa_ok;
        for (int i = 0; i < 2; i++) begin
            t = '0;
            if (busy_m[i] > 0) begin
                busy_m[i]--;
            end else begin
                ra_ok = (int'(rd_addr) < depth_m[i]);
                wa_ok = (int'(wr_addr) < depth_m[i]);
                if ((wren && !wa_ok) || (rden && !ra_ok)) err_m[i] = 1'b1;
                if (rden) begin
                    t.v = 1'b1;
                    if (ra_ok) begin
                        d = mem_m[i][rd_addr];
                        if (mode_m[i] == 1 && wren && wa_ok && wr_addr == rd_addr)
                            d = merge(d, datain, byteen);
                        t.d = d;
                    end
                end
                if (wren && wa_ok) mem_m[i][wr_addr] = merge(mem_m[i][wr_addr], datain, byteen);
            end
            q_m[i].push_back(t);
            if (q_m[i].size() == lat_m[i]) begin
                t = q_m[i].pop_front();
                ev_m[i] = t.v;
                if (t.v) ed_m[i] = t.d;
            end
        end
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        if (rst_n) model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [8:0] a, input logic [63:0] d, input logic [7:0] be);
        wren = 1'b1; wr_addr = a; datain = d; byteen = be; rden = 1'b0;
        step();
        wren = 1'b0;
    endtask

    // Issue one read (optionally with a same-cycle write) and capture the first
    // result of each instance together with its latency in cycles.
    task automatic access(input logic do_wr, input logic [8:0] wa, input logic [63:0] wd,
                          input logic [7:0] wbe, input logic [8:0] ra,
                          output logic [63:0] da, output int la,
                          output logic [63:0] db, output int lb);
        wren = do_wr; wr_addr = wa; datain = wd; byteen = wbe;
        rden = 1'b1; rd_addr = ra;
        la = 0; lb = 0; da = 'x; db = 'x;
        for (int k = 1; k <= 6; k++) begin
            step();
            wren = 1'b0; rden = 1'b0;
            if (dv_a && la == 0) begin la = k; da = dout_a; end
            if (dv_b && lb == 0) begin lb = k; db = dout_b; end
        end
    endtask

    // Count cycles from reset release until each init_busy falls.
    task automatic measure_init(output int fall_a, output int fall_b);
        fall_a = -1; fall_b = -1;
        for (int cyc = 1; cyc <= 600 && (fall_a < 0 || fall_b < 0); cyc++) begin
            step();
            if (!busy_a && fall_a < 0) fall_a = cyc;
            if (!busy_b && fall_b < 0) fall_b = cyc;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++; if (dout_a !== 64'h0 || dout_b !== 64'h0) begin n_fail++;
            $display("FAIL reset_dataout: got a=%h b=%h expected 0", dout_a, dout_b); end
        n_checks++; if (dv_a !== 1'b0 || dv_b !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid: got a=%b b=%b expected 0", dv_a, dv_b); end
        n_checks++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin n_fail++;
            $display("FAIL reset_busy: got a=%b b=%b expected 1", busy_a, busy_b); end
        n_checks++; if (err_a !== 1'b0 || err_b !== 1'b0) begin n_fail++;
            $display("FAIL reset_err: got a=%b b=%b expected 0", err_a, err_b); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        int fa, fb, la, lb;
        logic [63:0] da, db;
        logic saw;
        saw = 1'b0;
        // Requests during the sweep, including out-of-range ones, must be ignored.
        wren = 1'b1; rden = 1'b1; wr_addr = 9'd510; rd_addr = 9'd510; datain = '1; byteen = '1;
        for (int c = 0; c < 400; c++) begin
            step();
            if (dv_a || dv_b || err_a || err_b) saw = 1'b1;
        end
        wren = 1'b0; rden = 1'b0;
        n_checks++; if (saw !== 1'b0) begin n_fail++;
            $display("FAIL init_ignores_requests: got activity=%b expected 0", saw); end
        fa = -1; fb = -1;
        for (int cyc = 401; cyc <= 600 && (fa < 0 || fb < 0); cyc++) begin
            step();
            if (!busy_a && fa < 0) fa = cyc;
            if (!busy_b && fb < 0) fb = cyc;
        end
        n_checks++; if (fa != 512) begin n_fail++;
            $display("FAIL init_len_a: got %0d expected 512", fa); end
        n_checks++; if (fb != 500) begin n_fail++;
            $display("FAIL init_len_b: got %0d expected 500", fb); end
        access(1'b0, 9'd0, '0, '0, 9'd100, da, la, db, lb);
        n_checks++; if (da !== 64'h0 || la != 3) begin n_fail++;
            $display("FAIL init_read_a: got %h lat %0d expected 0 lat 3", da, la); end
        n_checks++; if (db !== IVAL_B || lb != 1) begin n_fail++;
            $display("FAIL init_read_b: got %h lat %0d expected %h lat 1", db, lb, IVAL_B); end
    endtask

    task automatic test_byte_mask();
        int la, lb;
        logic [63:0] da, db;
        wr(9'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(9'd7, 64'h1122_3344_5566_7788, 8'h0F);
        access(1'b0, 9'd0, '0, '0, 9'd7, da, la, db, lb);
        n_checks++; if (da !== 64'hFFFF_FFFF_5566_7788) begin n_fail++;
            $display("FAIL byte_mask_a: got %h expected FFFFFFFF55667788", da); end
        n_checks++; if (db !== 64'hFFFF_FFFF_5566_7788) begin n_fail++;
            $display("FAIL byte_mask_b: got %h expected FFFFFFFF55667788", db); end
        // A zero byte mask leaves the word untouched.
        wr(9'd7, 64'h0, 8'h00);
        access(1'b0, 9'd0, '0, '0, 9'd7, da, la, db, lb);
        n_checks++; if (da !== 64'hFFFF_FFFF_5566_7788 || db !== 64'hFFFF_FFFF_5566_7788) begin n_fail++;
            $display("FAIL zero_mask: got a=%h b=%h expected FFFFFFFF55667788", da, db); end
    endtask

    task automatic test_collision();
        int la, lb;
        logic [63:0] da, db;
        wr(9'd5, {8{8'hAA}}, 8'hFF);
        access(1'b1, 9'd5, {8{8'h55}}, 8'hFF, 9'd5, da, la, db, lb);
        n_checks++; if (da !== {8{8'hAA}}) begin n_fail++;
            $display("FAIL rdw_old_a: got %h expected AAAAAAAAAAAAAAAA", da); end
        n_checks++; if (db !== {8{8'h55}}) begin n_fail++;
            $display("FAIL rdw_new_full_b: got %h expected 5555555555555555", db); end
        access(1'b0, 9'd0, '0, '0, 9'd5, da, la, db, lb);
        n_checks++; if (da !== {8{8'h55}} || db !== {8{8'h55}}) begin n_fail++;
            $display("FAIL rdw_after: got a=%h b=%h expected 5555555555555555", da, db); end
        wr(9'd5, {8{8'hAA}}, 8'hFF);
        access(1'b1, 9'd5, {8{8'h55}}, 8'h01, 9'd5, da, la, db, lb);
        n_checks++; if (da !== {8{8'hAA}}) begin n_fail++;
            $display("FAIL rdw_old_byte_a: got %h expected AAAAAAAAAAAAAAAA", da); end
        n_checks++; if (db !== 64'hAAAA_AAAA_AAAA_AA55) begin n_fail++;
            $display("FAIL rdw_new_byte_b: got %h expected AAAAAAAAAAAAAA55", db); end
    endtask

    task automatic test_out_of_range();
        int la, lb;
        logic [63:0] da, db, wd;
        n_checks++; if (err_a !== 1'b0 || err_b !== 1'b0) begin n_fail++;
            $display("FAIL err_before: got a=%b b=%b expected 0", err_a, err_b); end
        access(1'b0, 9'd0, '0, '0, 9'd510, da, la, db, lb);
        n_checks++; if (db !== 64'h0 || lb != 1) begin n_fail++;
            $display("FAIL oor_read_b: got %h lat %0d expected 0 lat 1", db, lb); end
        n_checks++; if (err_b !== 1'b1 || err_a !== 1'b0) begin n_fail++;
            $display("FAIL oor_err: got a=%b b=%b expected a=0 b=1", err_a, err_b); end
        wd = {$urandom, $urandom};
        wr(9'd510, wd, 8'hFF);
        access(1'b0, 9'd0, '0, '0, 9'd10, da, la, db, lb);
        n_checks++; if (db !== IVAL_B) begin n_fail++;
            $display("FAIL oor_write_alias10_b: got %h expected %h", db, IVAL_B); end
        access(1'b0, 9'd0, '0, '0, 9'd254, da, la, db, lb);
        n_checks++; if (db !== IVAL_B) begin n_fail++;
            $display("FAIL oor_write_alias254_b: got %h expected %h", db, IVAL_B); end
        access(1'b0, 9'd0, '0, '0, 9'd510, da, la, db, lb);
        n_checks++; if (da !== wd) begin n_fail++;
            $display("FAIL inrange_510_a: got %h expected %h", da, wd); end
        n_checks++; if (err_b !== 1'b1) begin n_fail++;
            $display("FAIL err_sticky: got %b expected 1", err_b); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wren    = 1'($urandom_range(0, 1));
            rden    = 1'($urandom_range(0, 1));
            wr_addr = 9'($urandom_range(0, 511));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 9'($urandom_range(0, 511));
            datain  = {$urandom, $urandom};
            byteen  = 8'($urandom);
            step();
            n_checks++; if (dv_a !== ev_m[0] || dout_a !== ed_m[0]) begin n_fail++;
                $display("FAIL rand_a c%0d: got v=%b d=%h expected v=%b d=%h", c, dv_a, dout_a, ev_m[0], ed_m[0]); end
            n_checks++; if (dv_b !== ev_m[1] || dout_b !== ed_m[1]) begin n_fail++;
                $display("FAIL rand_b c%0d: got v=%b d=%h expected v=%b d=%h", c, dv_b, dout_b, ev_m[1], ed_m[1]); end
            n_checks++; if (err_a !== err_m[0] || err_b !== err_m[1]) begin n_fail++;
                $display("FAIL rand_err c%0d: got a=%b b=%b expected a=%b b=%b", c, err_a, err_b, err_m[0], err_m[1]); end
        end
        wren = 1'b0; rden = 1'b0;
        step();
    endtask

    task automatic test_reset_flush();
        logic saw;
        saw = 1'b0;
        rden = 1'b1; rd_addr = 9'd3; wren = 1'b0;
        step();
        step();
        rden = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (dv_a !== 1'b0) begin n_fail++;
            $display("FAIL flush_async: got valid=%b expected 0", dv_a); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (dv_a || dv_b) saw = 1'b1;
        end
        n_checks++; if (saw !== 1'b0) begin n_fail++;
            $display("FAIL flush_no_valid: got valid seen=%b expected 0", saw); end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++;
            $display("FAIL flush_reinit: got busy=%b expected 1", busy_a); end
    endtask

    task automatic test_reset_mid_init();
        int fa, fb, la, lb;
        logic [63:0] da, db;
        repeat (190) step();
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++; if (busy_a !== 1'b1 || dout_a !== 64'h0 || dv_a !== 1'b0) begin n_fail++;
            $display("FAIL midinit_reset: got busy=%b d=%h v=%b expected 1 0 0", busy_a, dout_a, dv_a); end
        @(negedge clk);
        rst_n = 1'b1;
        measure_init(fa, fb);
        n_checks++; if (fa != 512 || fb != 500) begin n_fail++;
            $display("FAIL midinit_len: got a=%0d b=%0d expected 512 500", fa, fb); end
        access(1'b0, 9'd0, '0, '0, 9'd7, da, la, db, lb);
        n_checks++; if (da !== 64'h0 || db !== IVAL_B) begin n_fail++;
            $display("FAIL midinit_clean: got a=%h b=%h expected 0 %h", da, db, IVAL_B); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_byte_mask();
        test_collision();
        test_out_of_range();
        test_random();
        test_reset_flush();
        test_reset_mid_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
